// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd_pkg;

  // Sequencer states: waiting for a word, folding digits, holding a result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_MAX    = 9;
  localparam int BCD_NIBBLE_W = 4;

  // A nibble is not a decimal digit when it exceeds 9
  function automatic logic digit_bad(input logic [BCD_NIBBLE_W-1:0] d);
    return (d > BCD_NIBBLE_W'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - input word and result handshakes of the converter
interface bcd_to_bin_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);

  logic                             in_valid;
  logic                             in_ready;
  logic [BCD_NIBBLE_W*DIGITS-1:0]   in_bcd;
  logic                             out_valid;
  logic                             out_ready;
  logic [OUT_W-1:0]                 out_bin;
  logic                             out_err;

  // Source of BCD words and consumer of results
  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  // The converter itself
  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - one Horner step: acc*10 + d with bad-digit flag
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int OUT_W = 14
) (
  input  logic [OUT_W-1:0]        acc_i,
  input  logic [BCD_NIBBLE_W-1:0] d_i,
  output logic [OUT_W-1:0]        acc_o,
  output logic                    d_bad_o
);

  logic [OUT_W-1:0] acc_x10;

  // Multiply by ten with two shifts and an add; overflow past OUT_W is dropped
  always_comb begin
    acc_x10 = (acc_i << 3) + (acc_i << 1);
    acc_o   = acc_x10 + OUT_W'(d_i);
    d_bad_o = digit_bad(d_i);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential handshaked multi-digit BCD to binary converter
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_seq_if.slave   bus,
  output logic              busy,
  output logic [CNT_W-1:0]  conv_cnt
);

  localparam int WORD_W = BCD_NIBBLE_W * DIGITS;
  // Keep the digit counter at least one bit wide so DIGITS=1 still builds
  localparam int DCNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [OUT_W-1:0]    acc_q,   acc_d;
  logic                err_q,   err_d;
  logic [DCNT_W-1:0]   dcnt_q,  dcnt_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [OUT_W-1:0]    obin_q,  obin_d;
  logic                oerr_q,  oerr_d;

  logic [BCD_NIBBLE_W-1:0] top_digit;
  logic [OUT_W-1:0]        mac_acc;
  logic                    mac_bad;
  logic                    err_next;

  assign top_digit = shift_q[WORD_W-1 -: BCD_NIBBLE_W];

  bcd_digit_mac #(.OUT_W(OUT_W)) u_mac (
    .acc_i   (acc_q),
    .d_i     (top_digit),
    .acc_o   (mac_acc),
    .d_bad_o (mac_bad)
  );

  assign err_next = err_q | mac_bad;

  // Handshake flags depend only on the state register
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bin   = obin_q;
  assign bus.out_err   = oerr_q;
  assign busy          = (state_q != IDLE);
  assign conv_cnt      = cnt_q;

  // State and datapath registers, all cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      obin_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      obin_q  <= obin_d;
      oerr_q  <= oerr_d;
    end
  end

  // Next-state logic: accept a word, fold one digit per cycle, hold the result
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    err_d   = err_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    obin_d  = obin_q;
    oerr_d  = oerr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d = bus.in_bcd;
          acc_d   = '0;
          err_d   = 1'b0;
          dcnt_d  = '0;
          state_d = CONV;
        end
      end

      CONV: begin
        acc_d   = mac_acc;
        err_d   = err_next;
        shift_d = shift_q << BCD_NIBBLE_W;
        dcnt_d  = dcnt_q + DCNT_W'(1);
        if (dcnt_q == LAST_DIGIT) begin
          // A word with any bad nibble reports zero rather than a garbage value
          obin_d  = err_next ? '0 : mac_acc;
          oerr_d  = err_next;
          dcnt_d  = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          obin_d  = '0;
          oerr_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - scoreboard bench for the BCD-to-binary converter
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] conv_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [13:0] exp_bin_q[$];
  logic        exp_err_q[$];
  int          acc_cyc_q[$];
  int          hs_cyc_q[$];

  bcd_to_bin_seq_if #(.DIGITS(4), .OUT_W(14)) bus ();

  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .conv_cnt (conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every result handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        hs_cyc_q.push_back(cyc);
        if (exp_bin_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", bus.out_bin);
        end else begin
          logic [13:0] eb;
          logic        ee;
          eb = exp_bin_q.pop_front();
          ee = exp_err_q.pop_front();
          chk("out_bin", 32'(bus.out_bin), 32'(eb));
          chk("out_err", 32'(bus.out_err), 32'(ee));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and wait for its input handshake
  task automatic send(input logic [15:0] bcd, input bit push, input logic [13:0] eb,
                      input logic ee, input bit hold);
    bit ok;
    ok = 1'b0;
    if (push) begin
      exp_bin_q.push_back(eb);
      exp_err_q.push_back(ee);
    end
    bus.in_bcd   = bcd;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        acc_cyc_q.push_back(cyc);
        ok = 1'b1;
      end
    end
    #1;
    if (!hold) bus.in_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_bin_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
    step();
  endtask

  initial begin
    bit seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bin", 32'(bus.out_bin), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_cnt", 32'(conv_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1234 with latency checks
    send(16'h1234, 1'b1, 14'd1234, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("latency_low", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk("latency_high", 32'(bus.out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("cnt_after_1234", 32'(conv_cnt), 32'd1);
    step();

    // 9999 held under backpressure
    bus.out_ready = 1'b0;
    send(16'h9999, 1'b1, 14'd9999, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_bin", 32'(bus.out_bin), 32'd9999);
      chk("bp_out_err", 32'(bus.out_err), 32'd0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_cnt", 32'(conv_cnt), 32'd1);
      @(negedge clk);
    end
    step();
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_cnt_after", 32'(conv_cnt), 32'd2);
    chk("bp_valid_after", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("bp_cnt_single", 32'(conv_cnt), 32'd2);
    step();

    // Corners, bad digit, and error cleared on next word
    send(16'h0000, 1'b1, 14'd0, 1'b0, 1'b0);
    drain();
    send(16'h12A4, 1'b1, 14'd0, 1'b1, 1'b0);
    drain();
    send(16'h0042, 1'b1, 14'd42, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("cnt_before_rst", 32'(conv_cnt), 32'd5);
    step();

    // Reset after two digits of 5678
    send(16'h5678, 1'b0, 14'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(conv_cnt), 32'd0);
    step();
    send(16'h0007, 1'b1, 14'd7, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("cnt_after_7", 32'(conv_cnt), 32'd1);
    step();

    // Back-to-back words with in_valid held high
    send(16'h0001, 1'b1, 14'd1, 1'b0, 1'b1);
    send(16'h0002, 1'b1, 14'd2, 1'b0, 1'b0);
    drain();
    if (acc_cyc_q.size() >= 2)
      chk("b2b_accept_gap", 32'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-2]), 32'd6);
    else
      chk("b2b_accept_count", 32'(acc_cyc_q.size()), 32'd2);
    if (hs_cyc_q.size() >= 2)
      chk("b2b_output_gap", 32'(hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[hs_cyc_q.size()-2]), 32'd6);
    else
      chk("b2b_output_count", 32'(hs_cyc_q.size()), 32'd2);
    @(negedge clk);
    chk("cnt_final", 32'(conv_cnt), 32'd3);
    chk("scoreboard_empty", 32'(exp_bin_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential, handshaked BCD-to-binary converter for packed multi-digit BCD words. It accepts one BCD word per transaction and folds the digits most-significant first with a Horner multiply-accumulate (acc*10 + digit), one digit per clock. It returns the binary result with an invalid-digit flag. It replaces wide combinational `digit*10^k` sums on the decimal datapath and sits between the BCD entry source and binary consumers, with ready/valid backpressure on both sides.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per input word (1..8)
- OUT_W, 14, result width; must satisfy 2^OUT_W > 10^DIGITS - 1 (14 for 4 digits)
- CNT_W, 16, width of the completed-conversion counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word
- in_bcd  in  4*DIGITS  packed BCD, digit 0 in [3:0], most-significant digit in top nibble
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_bin  out  OUT_W  binary result
- out_err  out  1  at least one nibble of the word was > 9
- busy  out  1  high in CONV or DONE
- conv_cnt  out  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_bcd into the shift register, acc=0, dcnt=0, err=0 -> CONV.
- CONV:
  - in_ready=0.
  - Each cycle: take the top nibble d.
    - acc <= acc*10 + d, truncated to OUT_W bits. Compute acc*10 as (acc<<3)+(acc<<1).
    - err <= err | (d>9).
    - Shift the register left by 4.
    - dcnt++.
  - When dcnt==DIGITS-1 is being processed -> DONE.
- DONE:
  - out_valid=1.
  - out_bin=acc, or 0 if err=1.
  - out_err=err.
  - Hold all outputs stable until out_valid&out_ready. At that edge: conv_cnt++ -> IDLE.
- Invalid digits do not abort. The conversion always runs DIGITS cycles and is reported with out_err=1 and out_bin=0.
- in_valid during CONV/DONE is ignored (not accepted). The source must keep the word stable until its own handshake.

## Timing
- Reset values (rst_n=0 sampled at edge):
  - state=IDLE
  - in_ready=1
  - out_valid=0, out_bin=0, out_err=0
  - busy=0
  - conv_cnt=0
  - acc, shift register and dcnt = 0
- Latency:
  - Input handshake at edge E0.
  - Digits are processed at edges E1..E_DIGITS.
  - out_valid is high from the cycle after E_DIGITS, i.e. DIGITS cycles after acceptance.
- Throughput: with out_ready tied high, one word per DIGITS+2 cycles. Sequence is accept, DIGITS conversion cycles, DONE handshake, then IDLE for one cycle.
- out_valid is registered; out_bin and out_err come from registers (no combinational path from in_* to out_*).
- in_ready depends on state only; it has no combinational dependence on out_ready.
- Reset mid-CONV or mid-DONE:
  - Discards the word.
  - No output handshake occurs.
  - conv_cnt is cleared.
  - Outputs return to reset values at that edge.
- conv_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- DIGITS=1: CONV lasts one cycle.

## Structure
- Package bcd_pkg holds:
  - state enum {IDLE, CONV, DONE}
  - DIGIT_MAX=9
  - BCD_NIBBLE_W=4
- Sub-module bcd_digit_mac: purely combinational.
  - Inputs: acc[OUT_W], d[4].
  - Outputs: acc*10+d (truncated) and d_bad (d>9).
  - Instantiated once in the sequencer.
- Top-level bcd_to_bin_seq holds the FSM, shift register, dcnt, acc/err registers and conv_cnt.

## Test plan
- in_bcd=16'h1234 accepted at E0, out_ready=1 -> out_valid rises after E4, out_bin=1234 (0x04D2), out_err=0, conv_cnt=1.
- Corners:
  - in_bcd=16'h9999 -> out_bin=9999 (0x270F), out_err=0.
  - in_bcd=16'h0000 -> out_bin=0, out_err=0.
- in_bcd=16'h12A4 -> after 4 conversion cycles out_err=1, out_bin=0. A following 16'h0042 -> out_bin=42, out_err=0 (err cleared per word).
- Backpressure:
  - out_ready=0 for 5 cycles in DONE -> out_valid, out_bin and out_err held constant, in_ready=0 throughout.
  - Release -> single handshake, conv_cnt increments by exactly 1.
- rst_n=0 for one edge during CONV (after 2 digits of 16'h5678) -> next cycle state IDLE, in_ready=1, out_valid=0, conv_cnt=0. A new word 16'h0007 then yields out_bin=7.
- Back-to-back:
  - in_valid held high with 16'h0001, then 16'h0002, out_ready=1 -> handshakes exactly DIGITS+2=6 cycles apart.
  - Outputs 1 then 2.
  - No word accepted while busy=1.
